// File: rtl/dma_pkg.sv
// Shared types and constants for the single-channel DMA bus master.
package dma_pkg;

    localparam int unsigned ADDR_W        = 16;
    localparam int unsigned DATA_W        = 64;
    localparam int unsigned BUF_DEPTH_DEF = 4;
    localparam int unsigned LEN_W_DEF     = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_REQ    = 3'd1;
    localparam logic [2:0] ST_READ   = 3'd2;
    localparam logic [2:0] ST_RDRAIN = 3'd3;
    localparam logic [2:0] ST_WRITE  = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_REQ    = ST_REQ,
        S_READ   = ST_READ,
        S_RDRAIN = ST_RDRAIN,
        S_WRITE  = ST_WRITE,
        S_DONE   = ST_DONE
    } state_e;

endpackage

// File: rtl/dma_buf.sv
// Burst buffer: register file with one synchronous write port and one
// combinational read port. Contents are not reset.
module dma_buf
    import dma_pkg::*;
#(
    parameter int unsigned DEPTH = BUF_DEPTH_DEF,
    parameter int unsigned DW    = DATA_W,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [DW-1:0]    wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [DW-1:0]    rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    // Capture one word per enabled cycle.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dma_master.sv
// Single-channel DMA master: reads bursts of up to BUF_DEPTH words into a
// local buffer and writes them to the destination until the job is done.
module dma_master
    import dma_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = BUF_DEPTH_DEF,
    parameter int unsigned LEN_W     = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              m_req,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_dout,
    input  logic              m_grant,
    input  logic [DATA_W-1:0] m_din
);

    localparam int unsigned IDX_W = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
    logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]  burst_q, burst_d;
    // Words issued so far in the current READ or WRITE phase.
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              m_req_q, m_req_d;
    logic              m_wr_q, m_wr_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_dout_q, m_dout_d;

    logic              buf_we;
    logic [IDX_W-1:0]  buf_waddr;
    logic [IDX_W-1:0]  buf_raddr;
    logic [DATA_W-1:0] buf_rdata;
    logic [DATA_W-1:0] wr_word;

    function automatic logic [CNT_W-1:0] clamp_burst(input logic [LEN_W-1:0] rem);
        if (rem < LEN_W'(BUF_DEPTH)) begin
            return CNT_W'(rem);
        end
        return CNT_W'(BUF_DEPTH);
    endfunction

    dma_buf #(
        .DEPTH (BUF_DEPTH),
        .DW    (DATA_W),
        .IDX_W (IDX_W)
    ) u_buf (
        .clk     (clk),
        .we_i    (buf_we),
        .waddr_i (buf_waddr),
        .wdata_i (m_din),
        .raddr_i (buf_raddr),
        .rdata_o (buf_rdata)
    );

    // A one-word burst reads the slot being captured in the same cycle.
    assign wr_word = (buf_we && (buf_waddr == buf_raddr)) ? m_din : buf_rdata;

    // Buffer port steering: capture read data one cycle behind each issue.
    always_comb begin
        buf_we    = 1'b0;
        buf_waddr = '0;
        buf_raddr = IDX_W'(cnt_q);
        if (state_q == S_READ) begin
            buf_we    = m_grant && (cnt_q >= CNT_W'(2));
            buf_waddr = IDX_W'(cnt_q - CNT_W'(2));
        end else if (state_q == S_RDRAIN) begin
            buf_we    = m_grant;
            buf_waddr = IDX_W'(cnt_q - CNT_W'(1));
            buf_raddr = '0;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        src_ptr_d = src_ptr_q;
        dst_ptr_d = dst_ptr_q;
        rem_d     = rem_q;
        burst_d   = burst_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        m_wr_d    = 1'b0;
        m_addr_d  = '0;
        m_dout_d  = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (length != '0) begin
                        state_d   = S_REQ;
                        src_ptr_d = src_addr;
                        dst_ptr_d = dst_addr;
                        rem_d     = length;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_REQ: begin
                if (m_grant) begin
                    state_d   = S_READ;
                    burst_d   = clamp_burst(rem_q);
                    m_addr_d  = src_ptr_q;
                    src_ptr_d = src_ptr_q + ADDR_W'(1);
                    cnt_d     = CNT_W'(1);
                end
            end
            S_READ: begin
                if (!m_grant) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (cnt_q < burst_q) begin
                    m_addr_d  = src_ptr_q;
                    src_ptr_d = src_ptr_q + ADDR_W'(1);
                    cnt_d     = cnt_q + CNT_W'(1);
                end else begin
                    state_d  = S_RDRAIN;
                    m_addr_d = m_addr_q;
                end
            end
            S_RDRAIN: begin
                if (!m_grant) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d   = S_WRITE;
                    m_wr_d    = 1'b1;
                    m_addr_d  = dst_ptr_q;
                    m_dout_d  = wr_word;
                    dst_ptr_d = dst_ptr_q + ADDR_W'(1);
                    cnt_d     = CNT_W'(1);
                end
            end
            S_WRITE: begin
                if (!m_grant) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (cnt_q < burst_q) begin
                    m_wr_d    = 1'b1;
                    m_addr_d  = dst_ptr_q;
                    m_dout_d  = wr_word;
                    dst_ptr_d = dst_ptr_q + ADDR_W'(1);
                    cnt_d     = cnt_q + CNT_W'(1);
                end else begin
                    rem_d = rem_q - LEN_W'(burst_q);
                    if (rem_d != '0) begin
                        state_d   = S_READ;
                        burst_d   = clamp_burst(rem_d);
                        m_addr_d  = src_ptr_q;
                        src_ptr_d = src_ptr_q + ADDR_W'(1);
                        cnt_d     = CNT_W'(1);
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        m_req_d = (state_d == S_REQ) || (state_d == S_READ) ||
                  (state_d == S_RDRAIN) || (state_d == S_WRITE);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            src_ptr_q <= '0;
            dst_ptr_q <= '0;
            rem_q     <= '0;
            burst_q   <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            m_req_q   <= 1'b0;
            m_wr_q    <= 1'b0;
            m_addr_q  <= '0;
            m_dout_q  <= '0;
        end else begin
            state_q   <= state_d;
            src_ptr_q <= src_ptr_d;
            dst_ptr_q <= dst_ptr_d;
            rem_q     <= rem_d;
            burst_q   <= burst_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            m_req_q   <= m_req_d;
            m_wr_q    <= m_wr_d;
            m_addr_q  <= m_addr_d;
            m_dout_q  <= m_dout_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign m_req  = m_req_q;
    assign m_wr   = m_wr_q;
    assign m_addr = m_addr_q;
    assign m_dout = m_dout_q;

endmodule

// File: tb/tb_dma_master.sv
// Self-checking bench for dma_master: a bus slave backed by a keyed ROM and a
// per-cycle expected trace built from the job description.
module tb_dma_master;
    import dma_pkg::*;

    localparam int unsigned BD = 4;
    localparam int unsigned LW = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [15:0]       src_addr;
    logic [15:0]       dst_addr;
    logic [LW-1:0]     length;
    logic              busy;
    logic              done;
    logic              err;
    logic              m_req;
    logic              m_wr;
    logic [15:0]       m_addr;
    logic [63:0]       m_dout;
    logic              m_grant;
    logic [63:0]       m_din = 64'h0;
    logic              grant_q = 1'b0;
    logic              kill = 1'b0;
    logic [63:0]       key_a;
    logic [63:0]       key_b;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        req;
        logic        wr;
        logic        bsy;
        logic        dn;
        logic        er;
        logic [15:0] addr;
        logic [63:0] dout;
    } cyc_t;

    cyc_t exp_q[$];
    cyc_t obs_q[$];

    always #5 clk = ~clk;

    dma_master #(.BUF_DEPTH(BD), .LEN_W(LW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .length   (length),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .m_req    (m_req),
        .m_wr     (m_wr),
        .m_addr   (m_addr),
        .m_dout   (m_dout),
        .m_grant  (m_grant),
        .m_din    (m_din)
    );

    function automatic logic [63:0] rom(input logic [15:0] a);
        return {key_a[63:32] ^ {a, ~a}, key_b[31:0] ^ {16'(a * 16'd40503), a}};
    endfunction

    // Bus slave: grant one cycle after request, read data one cycle after address.
    always @(posedge clk) begin
        grant_q <= m_req;
        m_din   <= rom(m_addr);
    end
    assign m_grant = grant_q & ~kill;

    function automatic cyc_t mk(input logic req, input logic wr, input logic bsy,
                                input logic dn, input logic er,
                                input logic [15:0] addr, input logic [63:0] dout);
        cyc_t r;
        r.req = req; r.wr = wr; r.bsy = bsy; r.dn = dn; r.er = er;
        r.addr = addr; r.dout = dout;
        return r;
    endfunction

    // Expected outputs for cycles 1..done of a job with immediate grant.
    task automatic build_exp(input logic [15:0] src, input logic [15:0] dst, input int len);
        int rem = len;
        int b;
        logic [15:0] s = src;
        logic [15:0] d = dst;
        exp_q.delete();
        if (len == 0) begin
            exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 64'h0));
            return;
        end
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 64'h0));
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 64'h0));
        while (rem > 0) begin
            b = (rem < int'(BD)) ? rem : int'(BD);
            for (int i = 0; i < b; i++)
                exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'(s + i), 64'h0));
            exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'(s + b - 1), 64'h0));
            for (int i = 0; i < b; i++)
                exp_q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'(d + i), rom(16'(s + i))));
            s = 16'(s + b);
            d = 16'(d + b);
            rem -= b;
        end
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 64'h0));
    endtask

    task automatic append_idle(input int n, input logic er);
        for (int i = 0; i < n; i++)
            exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, er, 16'h0, 64'h0));
    endtask

    // Issue one start and record outputs for n_cycles following cycles.
    task automatic run_job(input logic [15:0] src, input logic [15:0] dst, input int len,
                           input int n_cycles, input int kill_at, input int restart_at);
        obs_q.delete();
        @(negedge clk);
        start = 1'b1; src_addr = src; dst_addr = dst; length = LW'(len);
        for (int c = 1; c <= n_cycles; c++) begin
            @(negedge clk);
            start = (c == restart_at);
            if (c == restart_at) begin
                src_addr = ~src; length = LW'(5);
            end
            obs_q.push_back({m_req, m_wr, busy, done, err, m_addr, m_dout});
            if (c == kill_at) kill = 1'b1;
        end
        start = 1'b0;
        kill  = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if ({busy, done, err, m_req, m_wr, m_addr, m_dout} !== 85'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", {busy, done, err, m_req, m_wr, m_addr, m_dout});
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_copy();
        build_exp(16'h0010, 16'h7000, 3);
        append_idle(2, 1'b0);
        run_job(16'h0010, 16'h7000, 3, exp_q.size(), 0, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL basic_copy cycle %0d: got %h want %h", i + 1, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (obs_q[9].dn !== 1'b1 || obs_q[6].addr !== 16'h7000 || obs_q[6].dout !== rom(16'h0010)) begin
            errors++;
            $display("FAIL basic_copy_landmarks: done10=%b addr7=%h dout7=%h want 1 7000 %h",
                     obs_q[9].dn, obs_q[6].addr, obs_q[6].dout, rom(16'h0010));
        end
    endtask

    task automatic test_multi_burst();
        build_exp(16'h0200, 16'h9000, 6);
        append_idle(3, 1'b0);
        run_job(16'h0200, 16'h9000, 6, exp_q.size(), 0, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL multi_burst cycle %0d: got %h want %h", i + 1, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_zero_length();
        build_exp(16'h1111, 16'h2222, 0);
        append_idle(3, 1'b0);
        run_job(16'h1111, 16'h2222, 0, exp_q.size(), 0, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL zero_length cycle %0d: got %h want %h", i + 1, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_wrap_ignored_start();
        build_exp(16'hFFFF, 16'h0100, 2);
        append_idle(6, 1'b0);
        run_job(16'hFFFF, 16'h0100, 2, exp_q.size(), 0, 4);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL wrap_ignored_start cycle %0d: got %h want %h", i + 1, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_grant_loss();
        // Second WRITE cycle of a three-word job: REQ(2) + READ(3) + RDRAIN(1) + 2.
        int k = 8;
        build_exp(16'h0040, 16'h5000, 3);
        while (exp_q.size() > k) void'(exp_q.pop_back());
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0, 64'h0));
        append_idle(4, 1'b1);
        run_job(16'h0040, 16'h5000, 3, exp_q.size(), k, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL grant_loss cycle %0d: got %h want %h", i + 1, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] s;
        logic [15:0] d;
        int len;
        for (int j = 0; j < 8; j++) begin
            s   = 16'($urandom);
            d   = 16'($urandom);
            len = int'($urandom_range(1, 13));
            build_exp(s, d, len);
            append_idle(2, 1'b0);
            run_job(s, d, len, exp_q.size(), 0, 0);
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL random job %0d len %0d cycle %0d: got %h want %h",
                             j, len, i + 1, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; src_addr = 16'h1234; dst_addr = 16'h4000; length = LW'(6);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (m_req !== 1'b1 || m_wr !== 1'b0 || m_addr !== 16'h1235) begin
            errors++;
            $display("FAIL reset_mid_pre: req=%b wr=%b addr=%h want 1 0 1235", m_req, m_wr, m_addr);
        end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        checks++;
        if ({m_req, busy, done, m_wr, err} !== 5'b0 || m_addr !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid_post: req=%b busy=%b done=%b wr=%b err=%b addr=%h want all 0",
                     m_req, busy, done, m_wr, err, m_addr);
        end
        build_exp(16'h3000, 16'h6000, 5);
        append_idle(2, 1'b0);
        run_job(16'h3000, 16'h6000, 5, exp_q.size(), 0, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL reset_mid_job cycle %0d: got %h want %h", i + 1, obs_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        src_addr = 16'h0;
        dst_addr = 16'h0;
        length   = '0;
        key_a    = {$urandom, $urandom};
        key_b    = {$urandom, $urandom};
        test_reset();
        test_basic_copy();
        test_multi_burst();
        test_zero_length();
        test_wrap_ignored_start();
        test_grant_loss();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_master.md
Name: dma_master

Overview:
- Single-channel bus master that sits directly upstream of the bus arbiter/decoder.
- It receives a copy job of N 64-bit words from a source word address to a destination word address.
- It requests the bus, reads a burst of up to BUF_DEPTH words into a local buffer, then writes that burst to the destination. It repeats until the count is exhausted.
- It drives the bus master-side signals (m_req, m_wr, m_addr, m_dout) and consumes m_grant and m_din.

Parameters:
- BUF_DEPTH, 4, burst buffer depth in 64-bit words. Legal values: 2, 4, 8.
- LEN_W, 16, width of the word-count input.

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- reset_n  in  1  reset.
- start  in  1  job start pulse; sampled only in IDLE.
- src_addr  in  16  source start word address.
- dst_addr  in  16  destination start word address.
- length  in  LEN_W  number of words to copy.
- busy  out  1  high from the cycle after an accepted start until the DONE cycle, inclusive.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky; set on grant loss; cleared by the next accepted start.
- m_req  out  1  bus request.
- m_wr  out  1  bus write strobe (1 = write).
- m_addr  out  16  bus address.
- m_dout  out  64  write data.
- m_grant  in  1  bus grant.
- m_din  in  64  read data.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset is synchronous and active-low on reset_n: sampled only at the rising edge of clk.
  - During reset, all outputs are 0, state = IDLE, and the buffer contents are don't-care.
- Registered outputs: all outputs are registered.
  - m_wr = 0 and m_dout = 0 in every state except WRITE.
  - m_addr = 0 in IDLE, REQ and DONE.
- Bus timing contract:
  - Grant is visible on m_grant 1 cycle after m_req is first high.
  - Read data for an address driven in cycle k is valid on m_din in cycle k+1.
  - Writes are committed at the edge ending the cycle in which m_wr = 1.
- FSM states: IDLE, REQ, READ, RDRAIN, WRITE, DONE.
- IDLE:
  - start=1 with length≠0: latch src_ptr, dst_ptr and remaining; clear err; go to REQ.
  - start=1 with length=0: go to DONE with no bus activity.
  - start=0: stay in IDLE.
- REQ:
  - m_req=1.
  - m_grant=1 → READ; set burst = min(remaining, BUF_DEPTH).
- READ: runs for `burst` cycles.
  - Each cycle: m_addr = src_ptr, m_wr = 0, then src_ptr += 1.
  - In every READ cycle after the first, capture m_din into buf[rd_idx-1].
  - After the last issue cycle → RDRAIN.
- RDRAIN: 1 cycle; capture the last word; m_addr held at its last value; → WRITE.
- WRITE: runs for `burst` cycles.
  - Each cycle: m_wr = 1, m_addr = dst_ptr, m_dout = buf[wr_idx], then dst_ptr += 1.
  - After the last cycle: remaining -= burst. If remaining≠0 → READ with a new burst; else → DONE.
- m_req stays high continuously from REQ through the last WRITE cycle.
- DONE:
  - m_req = 0, done = 1 for exactly one cycle, busy = 1 in this cycle; → IDLE.
- Pointer arithmetic: pointers are 16-bit and wrap modulo 2^16 (0xFFFF+1 = 0x0000).
- Grant loss: m_grant = 0 while in READ, RDRAIN or WRITE → set err, issue no further bus cycles, → DONE.
- start while not in IDLE is ignored.
- Reset mid-transfer: the next edge with reset_n = 0 returns to IDLE; m_req, m_wr and done are 0 in the following cycle.
- Latency, assuming immediate grant:
  - Start sampled at edge 0.
  - REQ in cycle 1, grant seen in cycle 2.
  - READ begins in cycle 3.
  - Each burst of B words costs 2B+1 cycles; DONE follows the final WRITE.

Decomposition:
- Shared package dma_pkg holds:
  - the state encoding localparams (IDLE..DONE, 3-bit);
  - the default BUF_DEPTH;
  - address width 16 and data width 64.
- One sub-module, dma_buf:
  - BUF_DEPTH x 64 register file;
  - one synchronous write port (we, waddr, wdata);
  - one combinational read port (raddr → rdata);
  - no reset on contents.

Test Plan:
- Basic copy. Memory at 0x0010..0x0012 = A, B, C; start with src=0x0010, dst=0x7000, length=3.
  → m_req rises in cycle 1; reads in cycles 3-5 at 0x0010-0x0012; writes in cycles 7-9 to 0x7000-0x7002 with data A, B, C; done=1 in cycle 10; m_req=0 in cycle 10.
- Multi-burst. length=6, BUF_DEPTH=4.
  → First burst: 4 reads, then 4 writes. Second burst: 2 reads from src+4, then 2 writes to dst+4. m_req never drops between bursts. Single done pulse.
- Zero length. start with length=0.
  → done=1 in cycle 1; m_req never asserted; err=0.
- Wrap and ignored start. src=0xFFFF, length=2.
  → Read addresses are 0xFFFF, then 0x0000.
  → A second start pulse during READ is ignored: exactly one done pulse.
- Grant loss. Force m_grant=0 during the 2nd WRITE cycle.
  → No further m_wr; DONE on the next cycle; err=1 until the next accepted start.
- Reset mid-transfer. reset_n=0 for one edge during READ.
  → Next cycle: m_req=0, busy=0, done=0, m_wr=0.
  → A subsequent normal job completes correctly.
